// File: rtl/uart_transmit.sv
// FIFO-buffered UART transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit (11-bit frame instead of 10).
module uart_transmit #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] clk_div,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx,
    output logic        irq,
    output logic        busy,
    output logic        fifo_empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA      = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP_BIT  = 3'd4,
        DONE      = 3'd5
    } state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_period;
    logic [31:0]   r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_bit_end;
    logic [31:0]   w_period;
    logic          w_tx_d;
    logic          w_in_frame;
    logic          w_irq_d;

    assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = tx_valid & ~w_full;
    assign w_pop      = (r_state == IDLE) & ~w_empty;
    assign w_bit_end  = (r_cnt == '0);
    assign w_period   = (clk_div < 32'd2) ? 32'd2 : clk_div;
    assign tx_ready   = ~w_full;
    assign fifo_empty = w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_next = START_BIT;
                end
            end
            START_BIT: begin
                if (w_bit_end) begin
                    w_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_end && (r_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_next = PARITY;
`else
                    w_next = STOP_BIT;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_next = STOP_BIT;
                end
            end
`endif
            STOP_BIT: begin
                if (w_bit_end) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the current state and registered, so the line lags the FSM by one cycle.
    always_comb begin
        w_tx_d     = 1'b1;
        w_in_frame = 1'b0;
        w_irq_d    = 1'b0;
        case (r_state)
            START_BIT: begin
                w_tx_d     = 1'b0;
                w_in_frame = 1'b1;
            end
            DATA: begin
                w_tx_d     = r_shift[r_idx];
                w_in_frame = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                w_tx_d     = ^r_shift;
                w_in_frame = 1'b1;
            end
`endif
            STOP_BIT: begin
                w_in_frame = 1'b1;
            end
            DONE: begin
                w_irq_d = 1'b1;
            end
            default: begin
                w_tx_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx   <= 1'b1;
            busy <= 1'b0;
            irq  <= 1'b0;
        end else begin
            tx   <= w_tx_d;
            busy <= w_in_frame;
            irq  <= w_irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_period <= 32'd2;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
        end else if (w_pop) begin
            r_shift  <= r_mem[r_rptr];
            r_period <= w_period;
            r_cnt    <= w_period - 32'd1;
            r_idx    <= '0;
        end else if (w_in_frame) begin
            if (w_bit_end) begin
                r_cnt <= r_period - 32'd1;
                if (r_state == DATA) begin
                    r_idx <= r_idx + 3'd1;
                end
            end else begin
                r_cnt <= r_cnt - 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_transmit.sv
// Scoreboard bench for uart_transmit: a cycle-level FIFO/occupancy model predicts frames,
// a line monitor decodes tx and compares each frame, its irq pulse and inter-frame gap.
`timescale 1ns/1ps
module tb_uart_transmit;

    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] clk_div = 32'd16;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        tx;
    logic        irq;
    logic        busy;
    logic        fifo_empty;

    always #5 clk = ~clk;

    uart_transmit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .irq        (irq),
        .busy       (busy),
        .fifo_empty (fifo_empty)
    );

    typedef struct {
        logic [7:0] data;
        int         per;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   irq_cnt = 0;
    bit   mon_en = 1'b1;
    bit   mon_busy = 1'b0;

    logic [7:0] m_fifo[$];
    exp_t       exp_q[$];
    longint     cyc = 0;
    longint     m_free = 0;
    bit         do_pop;
    bit         do_push;
    exp_t       m_e;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: bytes wait in a FIFO of DEPTH entries; an idle transmitter takes the
    // head at a clock edge and is free again NB bit periods plus two cycles later.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_fifo.delete();
                exp_q.delete();
                m_free = cyc + 1;
            end else begin
                do_pop  = (cyc >= m_free) && (m_fifo.size() > 0);
                do_push = tx_valid && (m_fifo.size() < DEPTH);
                if (do_pop) begin
                    m_e.data = m_fifo.pop_front();
                    m_e.per  = (clk_div < 2) ? 2 : int'(clk_div);
                    exp_q.push_back(m_e);
                    m_free = cyc + longint'(NB) * m_e.per + 2;
                end
                if (do_push) begin
                    m_fifo.push_back(tx_data);
                end
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("tx_ready", tx_ready, m_fifo.size() < DEPTH);
                check("fifo_empty", fifo_empty, m_fifo.size() == 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (irq) irq_cnt++;
        end
    end

    // Line monitor: on a falling tx, compare the whole frame sample by sample.
    initial begin
        int   idle_run;
        bit   expect_gap;
        bit   bad;
        int   first_bad;
        logic got_tx;
        logic bits [0:NB-1];
        exp_t e;
        int   n;
        idle_run   = 0;
        expect_gap = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                idle_run   = 0;
                expect_gap = 1'b0;
            end else if (tx === 1'b1) begin
                idle_run++;
                check("irq_idle", irq, 0);
            end else begin
                mon_busy = 1'b1;
                if (expect_gap) check("frame_gap", idle_run, 2);
                check("frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() == 0) begin
                    n = 0;
                    while (tx !== 1'b1 && n < 3000) begin
                        @(negedge clk);
                        n++;
                    end
                end else begin
                    e = exp_q.pop_front();
                    bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) bits[1+i] = e.data[i];
`ifdef UART_TX_PARITY_EN
                    bits[9] = ^e.data;
`endif
                    bits[NB-1] = 1'b1;
                    bad       = 1'b0;
                    first_bad = -1;
                    got_tx    = 1'b0;
                    for (int k = 0; k < NB * e.per; k++) begin
                        if (k > 0) @(negedge clk);
                        if (tx !== bits[k / e.per] || busy !== 1'b1 || irq !== 1'b0) begin
                            if (!bad) begin
                                first_bad = k;
                                got_tx    = tx;
                            end
                            bad = 1'b1;
                        end
                    end
                    checks++;
                    if (bad) begin
                        errors++;
                        $display("FAIL frame_%02h: sample %0d got tx=%b (busy/irq checked too), required tx=%b period %0d",
                                 e.data, first_bad, got_tx, bits[first_bad / e.per], e.per);
                    end
                    @(negedge clk);
                    check("irq_pulse", irq, 1);
                    check("done_tx", tx, 1);
                    check("done_busy", busy, 0);
                    expect_gap = (m_fifo.size() > 0);
                end
                idle_run = 1;
                mon_busy = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
    endtask

    task automatic stop_send();
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((m_fifo.size() != 0 || exp_q.size() != 0 || mon_busy || cyc < m_free) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", n < max_cyc, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int pat [0:5];
        int n;
        int lows;
        int irqs;
        logic [7:0] b81;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_irq", irq, 0);
        check("rst_fifo_empty", fifo_empty, 1);
        check("rst_tx_ready", tx_ready, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0xA5 at 16 cycles per bit, with start latency
        clk_div = 32'd16;
        send(8'hA5);
        @(negedge clk);
        tx_valid = 1'b0;
        check("latency_c1_tx", tx, 1);
        @(negedge clk);
        check("latency_c2_tx", tx, 1);
        @(negedge clk);
        check("latency_c3_tx", tx, 0);
        drain(400);

        // Back-to-back frames
        clk_div = 32'd8;
        c0 = irq_cnt;
        send(8'h00);
        send(8'hFF);
        send(8'h3C);
        stop_send();
        drain(600);
        check("irq_count_3", irq_cnt - c0, 3);

        // Minimum bit period
        clk_div = 32'd0;
        send(8'h55);
        stop_send();
        drain(200);
        clk_div = 32'd1;
        send(8'h55);
        stop_send();
        drain(200);

        // Parity patterns (plain 8N1 frames when parity is disabled)
        clk_div = 32'd4;
        send(8'h07);
        send(8'h03);
        stop_send();
        drain(300);

        // Overflow: six pushes on consecutive cycles into a depth-4 FIFO
        clk_div = 32'd100;
        c0 = irq_cnt;
        pat = '{1, 1, 1, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            send(8'($urandom));
            check($sformatf("burst_ready_%0d", i), tx_ready, pat[i]);
        end
        stop_send();
        drain(8000);
        check("irq_count_5", irq_cnt - c0, 5);

        // Randomized traffic with clk_div changing mid-frame
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (c % 60 == 0) clk_div = $urandom_range(0, 6);
                tx_valid = ($urandom_range(0, 3) == 0);
                tx_data  = 8'($urandom);
            end
            stop_send();
            drain(3000);
        end

        // Reset in the middle of data bit 3 of 0x81 with two bytes queued
        mon_en  = 1'b0;
        clk_div = 32'd4;
        b81     = 8'h81;
        repeat (2) @(negedge clk);
        send(b81);
        send(8'h11);
        send(8'h22);
        stop_send();
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_start_seen", n < 20, 1);
        repeat (4 * 4 + 1) @(negedge clk);
        check("rst_test_bit3", tx, b81[3]);
        c0  = irq_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx", tx, 1);
        check("midrst_fifo_empty", fifo_empty, 1);
        check("midrst_busy", busy, 0);
        check("midrst_tx_ready", tx_ready, 1);
        lows = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        irqs = irq_cnt - c0;
        check("midrst_no_tx_activity", lows, 0);
        check("midrst_no_irq", irqs, 0);
        mon_en = 1'b1;

        check("scoreboard_empty", exp_q.size() + m_fifo.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
